dist_minmax_engine: RTL and testbench

Hardware engine for the program-2 workload: on a start handshake it reads 32 signed 16-bit operands from the byte-wide data memory, finds the minimum and maximum absolute difference over all 496 unordered pairs, and writes both results back to data memory. It connects to the same data-memory port as the core and uses the same start/done protocol, so the test bench can drive either the core or this engine and check memory bytes 66..69 the same way.

---
 rtl/dist_minmax_engine.sv | 182 ++++++++++++++++++
 tb/tb_dist_minmax_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dist_minmax_engine.sv
// Min/max absolute pairwise distance over 32 signed 16-bit operands read from byte memory.
// Optional build macro DIST_IDX_EN adds pair-index tracking and writes bytes 70..73.
module dist_minmax_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  output logic [15:0] min_dist,
  output logic [15:0] max_dist
);

`ifdef DIST_IDX_EN
  localparam logic [2:0] LAST_WR = 3'd7;
`else
  localparam logic [2:0] LAST_WR = 3'd3;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_armed, r_done, r_wr_en;
  logic [7:0]  r_addr, r_wr_data, r_hi;
  logic [4:0]  r_j, r_k;
  logic [2:0]  r_wcnt;
  logic [15:0] r_min, r_max;
  logic [15:0] r_ops [32];
  logic [16:0] w_diff;
  logic [15:0] w_dist, w_min_nxt, w_max_nxt;
  logic        w_min_upd, w_max_upd, w_scan_last;
  logic [7:0]  w_bytes [8];
`ifdef DIST_IDX_EN
  logic [4:0]  r_min_j, r_min_k, r_max_j, r_max_k;
  logic [4:0]  w_min_j_nxt, w_min_k_nxt, w_max_j_nxt, w_max_k_nxt;
`endif

  assign done        = r_done;
  assign mem_addr    = r_addr;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_data = r_wr_data;
  assign min_dist    = r_min;
  assign max_dist    = r_max;

  // 17-bit difference cannot overflow; |diff| <= 65535 so the low 16 bits of the negation are exact.
  assign w_diff      = {r_ops[r_j][15], r_ops[r_j]} - {r_ops[r_k][15], r_ops[r_k]};
  assign w_dist      = w_diff[16] ? (~w_diff[15:0] + 16'd1) : w_diff[15:0];
  assign w_min_upd   = (r_state == SCAN) && (w_dist < r_min);
  assign w_max_upd   = (r_state == SCAN) && (w_dist > r_max);
  assign w_min_nxt   = w_min_upd ? w_dist : r_min;
  assign w_max_nxt   = w_max_upd ? w_dist : r_max;
  assign w_scan_last = (r_j == 5'd30) && (r_k == 5'd31);
`ifdef DIST_IDX_EN
  assign w_min_j_nxt = w_min_upd ? r_j : r_min_j;
  assign w_min_k_nxt = w_min_upd ? r_k : r_min_k;
  assign w_max_j_nxt = w_max_upd ? r_j : r_max_j;
  assign w_max_k_nxt = w_max_upd ? r_k : r_max_k;
`endif

  // Result bytes in write order; built from next values so the final pair is included.
  always_comb begin
    w_bytes[0] = w_min_nxt[15:8];
    w_bytes[1] = w_min_nxt[7:0];
    w_bytes[2] = w_max_nxt[15:8];
    w_bytes[3] = w_max_nxt[7:0];
`ifdef DIST_IDX_EN
    w_bytes[4] = {3'd0, w_min_j_nxt};
    w_bytes[5] = {3'd0, w_min_k_nxt};
    w_bytes[6] = {3'd0, w_max_j_nxt};
    w_bytes[7] = {3'd0, w_max_k_nxt};
`else
    w_bytes[4] = 8'd0;
    w_bytes[5] = 8'd0;
    w_bytes[6] = 8'd0;
    w_bytes[7] = 8'd0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!start && r_armed)       w_state_nxt = LOAD;  else w_state_nxt = IDLE;
      LOAD:    if (r_addr == 8'd63)         w_state_nxt = SCAN;  else w_state_nxt = LOAD;
      SCAN:    if (w_scan_last)             w_state_nxt = WRITE; else w_state_nxt = SCAN;
      WRITE:   if (r_wcnt == LAST_WR)       w_state_nxt = DONE;  else w_state_nxt = WRITE;
      DONE:    if (start)                   w_state_nxt = IDLE;  else w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load, pair scan, result write-back and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed   <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= 8'd0;
      r_wr_data <= 8'd0;
      r_hi      <= 8'd0;
      r_j       <= 5'd0;
      r_k       <= 5'd1;
      r_wcnt    <= 3'd0;
      r_min     <= 16'hFFFF;
      r_max     <= 16'd0;
      for (int i = 0; i < 32; i++) r_ops[i] <= 16'd0;
`ifdef DIST_IDX_EN
      r_min_j <= 5'd0; r_min_k <= 5'd0; r_max_j <= 5'd0; r_max_k <= 5'd0;
`endif
    end else begin
      r_min  <= w_min_nxt;
      r_max  <= w_max_nxt;
      r_done <= 1'b0;
`ifdef DIST_IDX_EN
      r_min_j <= w_min_j_nxt; r_min_k <= w_min_k_nxt;
      r_max_j <= w_max_j_nxt; r_max_k <= w_max_k_nxt;
`endif
      case (r_state)
        IDLE: begin
          if (start) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            r_addr  <= 8'd0;
            r_min   <= 16'hFFFF;
            r_max   <= 16'd0;
`ifdef DIST_IDX_EN
            r_min_j <= 5'd0; r_min_k <= 5'd0; r_max_j <= 5'd0; r_max_k <= 5'd0;
`endif
          end
        end
        LOAD: begin
          if (!r_addr[0]) r_hi <= mem_rd_data;
          else            r_ops[r_addr[5:1]] <= {r_hi, mem_rd_data};
          if (r_addr == 8'd63) begin
            r_addr <= 8'd0;
            r_j    <= 5'd0;
            r_k    <= 5'd1;
          end else begin
            r_addr <= r_addr + 8'd1;
          end
        end
        SCAN: begin
          if (w_scan_last) begin
            r_addr    <= 8'd66;
            r_wr_en   <= 1'b1;
            r_wr_data <= w_bytes[0];
            r_wcnt    <= 3'd0;
          end else if (r_k == 5'd31) begin
            r_j <= r_j + 5'd1;
            r_k <= r_j + 5'd2;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end
        WRITE: begin
          if (r_wcnt == LAST_WR) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= 8'd0;
            r_addr    <= 8'd0;
          end else begin
            r_wcnt    <= r_wcnt + 3'd1;
            r_addr    <= r_addr + 8'd1;
            r_wr_data <= w_bytes[r_wcnt + 3'd1];
          end
        end
        DONE: begin
          r_done <= !start;
          if (start) r_armed <= 1'b1;
        end
        default: r_armed <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_minmax_engine.sv
// Self-checking bench for dist_minmax_engine: directed table, random runs vs. pairwise model, reset corners.
module tb_dist_minmax_engine;

`ifdef DIST_IDX_EN
  localparam int EXP_LAT = 569;
  localparam int NWR     = 8;
  localparam int MAX_A   = 73;
`else
  localparam int EXP_LAT = 565;
  localparam int NWR     = 4;
  localparam int MAX_A   = 69;
`endif

  typedef struct packed {
    logic [15:0] mn;
    logic [15:0] mx;
`ifdef DIST_IDX_EN
    logic [4:0]  mnj;
    logic [4:0]  mnk;
    logic [4:0]  mxj;
    logic [4:0]  mxk;
`endif
  } res_t;

  typedef struct packed {
    logic [31:0][15:0] ops;
    res_t              exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, done, mem_wr_en, clr_log;
  logic [7:0]  mem_addr, mem_rd_data, mem_wr_data;
  logic [15:0] min_dist, max_dist;
  logic [7:0]  rd_mem [256];
  logic [7:0]  wr_mem [256];
  int          wr_cnt, bad_wr;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs [4];

  dist_minmax_engine dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .min_dist(min_dist), .max_dist(max_dist)
  );

  initial forever #5 clk = ~clk;

  assign mem_rd_data = rd_mem[mem_addr];

  always @(posedge clk) begin
    if (clr_log) begin
      wr_cnt <= 0;
      bad_wr <= 0;
      for (int i = 66; i <= 73; i++) wr_mem[i] <= 8'hAA;
    end else if (mem_wr_en) begin
      wr_mem[mem_addr] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < 8'd66 || int'(mem_addr) > MAX_A) bad_wr <= bad_wr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exhaustive pairs in (j,k) order with signed integer arithmetic.
  function automatic res_t ref_model(input logic [31:0][15:0] ops);
    res_t r;
    int   d, bmn, bmx;
    bmn = 65535;
    bmx = 0;
    r = '0;
    for (int j = 0; j < 31; j++)
      for (int k = j + 1; k < 32; k++) begin
        d = int'($signed(ops[j])) - int'($signed(ops[k]));
        if (d < 0) d = -d;
        if (d < bmn) begin
          bmn = d;
`ifdef DIST_IDX_EN
          r.mnj = 5'(j); r.mnk = 5'(k);
`endif
        end
        if (d > bmx) begin
          bmx = d;
`ifdef DIST_IDX_EN
          r.mxj = 5'(j); r.mxk = 5'(k);
`endif
        end
      end
    r.mn = 16'(bmn);
    r.mx = 16'(bmx);
    return r;
  endfunction

  task automatic do_run(input logic [31:0][15:0] ops, input res_t e, input string tag);
    int n;
    for (int i = 0; i < 32; i++) begin
      rd_mem[2*i]   = ops[i][15:8];
      rd_mem[2*i+1] = ops[i][7:0];
    end
    @(negedge clk); clr_log = 1'b1; start = 1'b1;
    @(negedge clk); clr_log = 1'b0; start = 1'b0;
    @(posedge clk);
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); n++; #1;
      if (n == 1) chk({tag, " first_load_addr"}, 32'(mem_addr), 32'd1);
    end
    chk({tag, " latency"}, 32'(n), 32'(EXP_LAT));
    chk({tag, " min_dist"}, 32'(min_dist), 32'(e.mn));
    chk({tag, " max_dist"}, 32'(max_dist), 32'(e.mx));
    chk({tag, " byte66"}, 32'(wr_mem[66]), 32'(e.mn[15:8]));
    chk({tag, " byte67"}, 32'(wr_mem[67]), 32'(e.mn[7:0]));
    chk({tag, " byte68"}, 32'(wr_mem[68]), 32'(e.mx[15:8]));
    chk({tag, " byte69"}, 32'(wr_mem[69]), 32'(e.mx[7:0]));
`ifdef DIST_IDX_EN
    chk({tag, " byte70"}, 32'(wr_mem[70]), 32'(e.mnj));
    chk({tag, " byte71"}, 32'(wr_mem[71]), 32'(e.mnk));
    chk({tag, " byte72"}, 32'(wr_mem[72]), 32'(e.mxj));
    chk({tag, " byte73"}, 32'(wr_mem[73]), 32'(e.mxk));
`endif
    chk({tag, " write_count"}, 32'(wr_cnt), 32'(NWR));
    chk({tag, " stray_writes"}, 32'(bad_wr), 32'd0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk({tag, " done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0][15:0] ops;
    res_t              e;

    for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      vecs[0].ops[i] = 16'h1234;
      vecs[1].ops[i] = (i == 0) ? 16'h8000 : ((i == 31) ? 16'h7FFF : 16'h0000);
      vecs[2].ops[i] = 16'(i * 3);
      vecs[3].ops[i] = (i < 3) ? 16'((i + 1) * 10) : 16'd1000;
    end
    vecs[0].exp.mn = 16'd0;    vecs[0].exp.mx = 16'd0;
    vecs[1].exp.mn = 16'd0;    vecs[1].exp.mx = 16'hFFFF;
    vecs[2].exp.mn = 16'd3;    vecs[2].exp.mx = 16'd93;
    vecs[3].exp.mn = 16'd0;    vecs[3].exp.mx = 16'd990;
`ifdef DIST_IDX_EN
    vecs[0].exp.mnj = 5'd0; vecs[0].exp.mnk = 5'd1; vecs[0].exp.mxj = 5'd0; vecs[0].exp.mxk = 5'd0;
    vecs[1].exp.mnj = 5'd1; vecs[1].exp.mnk = 5'd2; vecs[1].exp.mxj = 5'd0; vecs[1].exp.mxk = 5'd31;
    vecs[2].exp.mnj = 5'd0; vecs[2].exp.mnk = 5'd1; vecs[2].exp.mxj = 5'd0; vecs[2].exp.mxk = 5'd31;
    vecs[3].exp.mnj = 5'd3; vecs[3].exp.mnk = 5'd4; vecs[3].exp.mxj = 5'd0; vecs[3].exp.mxk = 5'd3;
`endif

    reset = 1'b1; start = 1'b0; clr_log = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst done", 32'(done), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst min", 32'(min_dist), 32'hFFFF);
    chk("rst max", 32'(max_dist), 32'd0);
    @(negedge clk); reset = 1'b0; clr_log = 1'b0;

    // Start held low without a prior high must never launch a run.
    repeat (700) @(posedge clk);
    #1;
    chk("idle_no_arm writes", 32'(wr_cnt), 32'd0);
    chk("idle_no_arm done", 32'(done), 32'd0);

    for (int v = 0; v < 4; v++) do_run(vecs[v].ops, vecs[v].exp, $sformatf("vec%0d", v));

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) begin
        case (r % 3)
          0:       ops[i] = 16'($urandom);
          1:       ops[i] = 16'($urandom_range(0, 7));
          default: ops[i] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'(32'h7FFF - $urandom_range(0, 3));
        endcase
      end
      e = ref_model(ops);
      do_run(ops, e, $sformatf("rand%0d", r));
    end

    // Reset in the middle of SCAN, then verify a clean follow-up run.
    for (int i = 0; i < 32; i++) ops[i] = 16'($urandom);
    for (int i = 0; i < 32; i++) begin
      rd_mem[2*i]   = ops[i][15:8];
      rd_mem[2*i+1] = ops[i][7:0];
    end
    @(negedge clk); clr_log = 1'b1; start = 1'b1;
    @(negedge clk); clr_log = 1'b0; start = 1'b0;
    @(posedge clk);
    repeat (364) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst min", 32'(min_dist), 32'hFFFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    chk("midrst writes", 32'(wr_cnt), 32'd0);
    chk("midrst done_after", 32'(done), 32'd0);
    chk("midrst wr_en", 32'(mem_wr_en), 32'd0);
    e = ref_model(ops);
    do_run(ops, e, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
